// File: rtl/fdiv32_pkg.sv
// Shared types and constants for the binary32 divider and its rounding stage.
package fdiv32_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned MANT_W    = FRAC_W + 1;
    localparam int unsigned XEXP_W    = 10;
    localparam int unsigned EXP_BIAS  = 127;
    localparam int unsigned QBITS_DEF = 27;
    localparam int unsigned CNT_W     = 5;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        OPC_DIV   = 2'b00,
        OPC_RECIP = 2'b01,
        OPC_RSV2  = 2'b10,
        OPC_RSV3  = 2'b11
    } opc_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Denormals are treated as signed zero throughout the datapath.
    function automatic fp32_t ftz(input fp32_t x);
        fp32_t r;
        r = x;
        if (x.exp == '0) begin
            r.frac = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_round.sv
// Rounds a normalised sign/exponent/mantissa triple to binary32 with
// overflow saturation per rounding mode and flush-to-zero underflow.
module fp32_round
    import fdiv32_pkg::*;
(
    input  logic                     sign,
    input  logic signed [XEXP_W-1:0] exp_in,
    input  logic [MANT_W-1:0]        mant,
    input  logic                     guard,
    input  logic                     sticky,
    input  rmode_e                   r_mode,
    output fp32_t                    result_c
);

    logic                     inc_c;
    logic                     to_inf_c;
    logic [MANT_W:0]          sum_c;
    logic [MANT_W-1:0]        mant_n_c;
    logic signed [XEXP_W-1:0] exp_n_c;

    always_comb begin
        inc_c    = 1'b0;
        to_inf_c = 1'b1;
        case (r_mode)
            RM_RNE: begin
                inc_c    = guard & (sticky | mant[0]);
                to_inf_c = 1'b1;
            end
            RM_RTZ: begin
                inc_c    = 1'b0;
                to_inf_c = 1'b0;
            end
            RM_RUP: begin
                inc_c    = (guard | sticky) & ~sign;
                to_inf_c = ~sign;
            end
            RM_RDN: begin
                inc_c    = (guard | sticky) & sign;
                to_inf_c = sign;
            end
            default: begin
                inc_c    = 1'b0;
                to_inf_c = 1'b1;
            end
        endcase

        // A carry out of the mantissa means it rolled over to 2.0.
        sum_c = {1'b0, mant} + (MANT_W+1)'(inc_c);
        if (sum_c[MANT_W]) begin
            mant_n_c = sum_c[MANT_W:1];
            exp_n_c  = exp_in + 10'sd1;
        end else begin
            mant_n_c = sum_c[MANT_W-1:0];
            exp_n_c  = exp_in;
        end

        result_c = '{sign: sign, exp: exp_n_c[EXP_W-1:0], frac: mant_n_c[FRAC_W-1:0]};
        if (exp_n_c >= 10'sd255) begin
            if (to_inf_c) begin
                result_c = '{sign: sign, exp: '1, frac: '0};
            end else begin
                result_c = '{sign: sign, exp: 8'hFE, frac: '1};
            end
        end else if (exp_n_c <= 10'sd0) begin
            result_c = '{sign: sign, exp: '0, frac: '0};
        end
    end

endmodule

// File: rtl/fdiv32.sv
// Iterative binary32 divider: special-case check, radix-2 restoring
// quotient generation (one bit per clock), then IEEE rounding.
module fdiv32
    import fdiv32_pkg::*;
#(
    parameter int unsigned QBITS = QBITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FP_W-1:0]   op1,
    input  logic [FP_W-1:0]   op2,
    input  logic [1:0]        opc,
    input  logic [1:0]        r_mode,
    output logic              busy,
    output logic [FP_W-1:0]   result,
    output logic              val
);

    localparam int unsigned REM_W = MANT_W + 1;

    state_e                   state_q,  state_d;
    logic [CNT_W-1:0]         cnt_q,    cnt_d;
    logic                     busy_q,   busy_d;
    logic                     val_q,    val_d;
    logic [FP_W-1:0]          result_q, result_d;
    logic [FP_W-1:0]          a_q,      a_d;
    logic [FP_W-1:0]          b_q,      b_d;
    opc_e                     opc_q,    opc_d;
    rmode_e                   rmode_q,  rmode_d;
    logic                     sign_q,   sign_d;
    logic signed [XEXP_W-1:0] exp_q,    exp_d;
    logic [REM_W-1:0]         rem_q,    rem_d;
    logic [MANT_W-1:0]        dvs_q,    dvs_d;
    logic [QBITS-1:0]         quo_q,    quo_d;

    fp32_t                    x_c, y_c;
    logic                     x_nan_c, y_nan_c, x_inf_c, y_inf_c, x_zero_c, y_zero_c;
    logic                     sign_c, special_c;
    logic [FP_W-1:0]          special_res_c;

    logic [REM_W:0]           trial_c;
    logic                     qbit_c;
    logic [REM_W-1:0]         rem_step_c;

    logic [MANT_W-1:0]        rnd_mant_c;
    logic                     rnd_guard_c, rnd_sticky_c;
    logic signed [XEXP_W-1:0] rnd_exp_c;
    fp32_t                    rnd_res_c;

    // Operand classification and special-result selection.
    always_comb begin
        x_c      = ftz((opc_q == OPC_RECIP) ? ONE : a_q);
        y_c      = ftz(b_q);
        x_nan_c  = (x_c.exp == '1) && (x_c.frac != '0);
        y_nan_c  = (y_c.exp == '1) && (y_c.frac != '0);
        x_inf_c  = (x_c.exp == '1) && (x_c.frac == '0);
        y_inf_c  = (y_c.exp == '1) && (y_c.frac == '0);
        x_zero_c = (x_c.exp == '0);
        y_zero_c = (y_c.exp == '0);
        sign_c   = x_c.sign ^ y_c.sign;

        special_c     = 1'b1;
        special_res_c = QNAN;
        if (x_nan_c || y_nan_c || (opc_q == OPC_RSV2) || (opc_q == OPC_RSV3)
            || (x_zero_c && y_zero_c) || (x_inf_c && y_inf_c)) begin
            special_res_c = QNAN;
        end else if (y_zero_c || x_inf_c) begin
            special_res_c = {sign_c, 8'hFF, 23'h0};
        end else if (x_zero_c || y_inf_c) begin
            special_res_c = {sign_c, 31'h0};
        end else begin
            special_c = 1'b0;
        end
    end

    // One restoring-division step.
    always_comb begin
        trial_c    = {1'b0, rem_q} - {2'b00, dvs_q};
        qbit_c     = ~trial_c[REM_W];
        rem_step_c = qbit_c ? trial_c[REM_W-1:0] : rem_q;
    end

    // Normalisation select: quotient is either in [1,2) or [0.5,1).
    always_comb begin
        if (quo_q[QBITS-1]) begin
            rnd_mant_c   = quo_q[QBITS-1 -: MANT_W];
            rnd_guard_c  = quo_q[QBITS-1-MANT_W];
            rnd_sticky_c = (|quo_q[QBITS-2-MANT_W:0]) | (|rem_q);
            rnd_exp_c    = exp_q;
        end else begin
            rnd_mant_c   = quo_q[QBITS-2 -: MANT_W];
            rnd_guard_c  = quo_q[QBITS-2-MANT_W];
            rnd_sticky_c = (|quo_q[QBITS-3-MANT_W:0]) | (|rem_q);
            rnd_exp_c    = exp_q - 10'sd1;
        end
    end

    fp32_round u_round (
        .sign     (sign_q),
        .exp_in   (rnd_exp_c),
        .mant     (rnd_mant_c),
        .guard    (rnd_guard_c),
        .sticky   (rnd_sticky_c),
        .r_mode   (rmode_q),
        .result_c (rnd_res_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        val_d    = 1'b0;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        opc_d    = opc_q;
        rmode_d  = rmode_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op1;
                    b_d     = op2;
                    opc_d   = opc_e'(opc);
                    rmode_d = rmode_e'(r_mode);
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                sign_d = sign_c;
                if (special_c) begin
                    result_d = special_res_c;
                    val_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    exp_d   = XEXP_W'(x_c.exp) - XEXP_W'(y_c.exp) + XEXP_W'(EXP_BIAS);
                    rem_d   = REM_W'({1'b1, x_c.frac});
                    dvs_d   = {1'b1, y_c.frac};
                    quo_d   = '0;
                    cnt_d   = CNT_W'(QBITS - 1);
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d = {rem_step_c[REM_W-2:0], 1'b0};
                quo_d = {quo_q[QBITS-2:0], qbit_c};
                if (cnt_q == '0) begin
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ROUND: begin
                result_d = rnd_res_c;
                val_d    = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            val_q    <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opc_q    <= OPC_DIV;
            rmode_q  <= RM_RNE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            val_q    <= val_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opc_q    <= opc_d;
            rmode_q  <= rmode_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
        end
    end

    assign busy   = busy_q;
    assign val    = val_q;
    assign result = result_q;

endmodule
